// File: rtl/register_file.sv
// MIPS 32x32 general-purpose register file: two combinational read ports, one
// synchronous write port, $zero hardwired, $gp/$sp loaded with MARS pointers on reset.
module register_file #(
    parameter int          N_BITS  = 32,
    parameter logic [31:0] SP_INIT = 32'h7FFF_EFFC,
    parameter logic [31:0] GP_INIT = 32'h1000_8000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        WriteRegister,
    input  logic [N_BITS-1:0] WriteData,
    input  logic [4:0]        ReadRegister1,
    input  logic [4:0]        ReadRegister2,
    output logic [N_BITS-1:0] ReadData1,
    output logic [N_BITS-1:0] ReadData2
);

    logic [N_BITS-1:0] regs_q [1:31];
    logic [N_BITS-1:0] regs_d [1:31];

    function automatic logic [N_BITS-1:0] reset_value(input int idx);
        if (idx == 28) return N_BITS'(GP_INIT);
        if (idx == 29) return N_BITS'(SP_INIT);
        return '0;
    endfunction

    // Index 0 never matches any slot, so a write to $zero falls through and is lost.
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if (RegWrite && (WriteRegister == 5'(i)))
                regs_d[i] = WriteData;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < 32; i++) begin
            if (!reset)
                regs_q[i] <= reset_value(i);
            else
                regs_q[i] <= regs_d[i];
        end
    end

    // Reads see only committed state; a bypass would close a loop through the ALU.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        for (int i = 1; i < 32; i++) begin
            if (ReadRegister1 == 5'(i)) ReadData1 = regs_q[i];
            if (ReadRegister2 == 5'(i)) ReadData2 = regs_q[i];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: array model checked every cycle plus directed literal checks.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [0:31];
    logic        model_vld = 1'b0;

    register_file dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    // Reference: reset restores pointers and zeros, otherwise a single write to nonzero index.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) model[i] <= 32'h0;
            model[28] <= 32'h1000_8000;
            model[29] <= 32'h7FFF_EFFC;
            model_vld <= 1'b1;
        end else if (RegWrite && WriteRegister != 5'd0) begin
            model[WriteRegister] <= WriteData;
        end
    end

    always @(negedge clk) begin
        if (model_vld) begin
            checks++;
            if (ReadData1 !== model[ReadRegister1] || ReadData2 !== model[ReadRegister2]) begin
                errors++;
                $display("FAIL cycle_cmp rs1=%0d rs2=%0d actual=%h/%h required=%h/%h",
                         ReadRegister1, ReadRegister2, ReadData1, ReadData2,
                         model[ReadRegister1], model[ReadRegister2]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_sweep();
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            step();
        end
    endtask

    initial begin
        reset = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hDEAD_BEEF;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        step();
        step();
        ReadRegister1 = 5'd28; ReadRegister2 = 5'd29; #1;
        chk("rst_gp", ReadData1, 32'h1000_8000);
        chk("rst_sp", ReadData2, 32'h7FFF_EFFC);
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd0; #1;
        chk("rst_r5", ReadData1, 32'h0);
        chk("rst_r0", ReadData2, 32'h0);
        reset = 1'b1;
        read_sweep();

        // Fill every register with its own pattern, then sweep both ports.
        for (int i = 1; i < 32; i++) begin
            RegWrite = 1'b1; WriteRegister = 5'(i); WriteData = 32'hA5A5_0000 | 32'(i);
            step();
        end
        read_sweep();
        ReadRegister1 = 5'd17; ReadRegister2 = 5'd31; #1;
        chk("wr_r17", ReadData1, 32'hA5A5_0011);
        chk("wr_r31", ReadData2, 32'hA5A5_001F);

        RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hFFFF_FFFF;
        step();
        RegWrite = 1'b0; ReadRegister1 = 5'd0; ReadRegister2 = 5'd0; #1;
        chk("zero_p1", ReadData1, 32'h0);
        chk("zero_p2", ReadData2, 32'h0);

        RegWrite = 1'b1; WriteRegister = 5'd8; WriteData = 32'h0000_0011;
        step();
        WriteData = 32'h0000_0022; ReadRegister1 = 5'd8; ReadRegister2 = 5'd8; #1;
        chk("nobyp_pre1", ReadData1, 32'h0000_0011);
        chk("nobyp_pre2", ReadData2, 32'h0000_0011);
        step();
        chk("nobyp_post1", ReadData1, 32'h0000_0022);
        chk("nobyp_post2", ReadData2, 32'h0000_0022);

        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'h1234_5678;
        step();
        RegWrite = 1'b0; WriteData = 32'h0; ReadRegister1 = 5'd9;
        step(); step(); step();
        chk("wen_low_r9", ReadData1, 32'h1234_5678);

        reset = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd29; WriteData = 32'h0;
        step();
        reset = 1'b1; RegWrite = 1'b0;
        ReadRegister1 = 5'd29; ReadRegister2 = 5'd8; #1;
        chk("mid_rst_sp", ReadData1, 32'h7FFF_EFFC);
        chk("mid_rst_r8", ReadData2, 32'h0);
        ReadRegister1 = 5'd9; ReadRegister2 = 5'd28; #1;
        chk("mid_rst_r9", ReadData1, 32'h0);
        chk("mid_rst_gp", ReadData2, 32'h1000_8000);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

32 x 32-bit MIPS general-purpose register file that sits directly upstream of the ALU. Two asynchronous read ports drive the ALU's A and B operands. The B operand reaches the ALU through the immediate mux. One synchronous write port takes the write-back value (ALU result or memory data) at the end of each instruction. Register $zero is hardwired to 0, and $sp/$gp come out of reset with MARS-compatible pointers.

## Interface
Parameters:
- N_BITS, 32, data width of every register and port.
- SP_INIT, 32'h7FFF_EFFC, reset value of register 29 ($sp).
- GP_INIT, 32'h1000_8000, reset value of register 28 ($gp).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- RegWrite  input  1  write enable for the write port.
- WriteRegister  input  5  destination register index.
- WriteData  input  N_BITS  value to write.
- ReadRegister1  input  5  index for read port 1 (rs).
- ReadRegister2  input  5  index for read port 2 (rt).
- ReadData1  output  N_BITS  contents of register ReadRegister1 (ALU operand A).
- ReadData2  output  N_BITS  contents of register ReadRegister2 (ALU operand B / store data).

## Operation
- Storage: 31 physical N_BITS registers, indices 1..31. Index 0 has no storage and always reads 0.
- Read: purely combinational. ReadDataX = 0 when ReadRegisterX == 0; otherwise it is the stored value of register ReadRegisterX.
- No write-to-read bypass. A read in the same cycle as a write to that index returns the old value until the clock edge. This is required: in the single-cycle datapath WriteData depends combinationally on ReadData, so a bypass would create a loop.
- Write, on rising edge with reset = 1:
  - If RegWrite = 1 and WriteRegister != 0, then reg[WriteRegister] <= WriteData.
  - All other registers hold.
  - A write to index 0 is silently discarded.
- Reset, on rising edge with reset = 0:
  - reg[28] <= GP_INIT and reg[29] <= SP_INIT.
  - Every other register <= 0.
  - RegWrite is ignored; reset has priority over any write in the same edge.

## Timing
- Read latency: 0 cycles (combinational from ReadRegisterX and register state).
- Write latency: 1 edge. The new value is visible on ReadDataX immediately after the rising edge that captures it.
- Output values while reset is held low and after the first edge:
  - ReadData1 and ReadData2 show 0 for every index except 28 (GP_INIT) and 29 (SP_INIT).
- Output values before the first reset edge are undefined; the bench must not check them.
- Reset mid-program: the first edge with reset = 0 restores all reset values regardless of RegWrite, WriteRegister or WriteData. The write presented on that edge is lost.
- Simultaneous events:
  - Both read ports may address the same register, including the one being written; both return the identical pre-edge value.
  - One write per cycle; no write-port contention.
- Width: no truncation or extension; WriteData is stored bit-exact.

## Test plan
- Reset: hold reset = 0 for 2 edges with RegWrite = 1, WriteRegister = 5, WriteData = 32'hDEAD_BEEF. Then read indices 0..31 on both ports. Required: 0 everywhere except reg28 = 32'h1000_8000 and reg29 = 32'h7FFF_EFFC; reg5 = 0.
- Write/read all: for i = 1..31 write 32'hA5A5_0000 | i, then read back on both ports. Required: each port returns the written pattern; ReadRegister = 0 returns 0.
- $zero protection: write 32'hFFFF_FFFF to index 0, then read index 0 on both ports. Required: 0.
- No bypass: reg8 = 32'h0000_0011. Present RegWrite = 1, WriteRegister = 8, WriteData = 32'h0000_0022, ReadRegister1 = ReadRegister2 = 8. Required: 32'h0000_0011 before the edge and 32'h0000_0022 after it.
- RegWrite low: reg9 = 32'h1234_5678. Present RegWrite = 0, WriteRegister = 9, WriteData = 0 for 3 edges. Required: reg9 stays 32'h1234_5678.
- Reset mid-operation: after the writes above, assert reset = 0 for one edge together with a write to reg29 of 32'h0. Required: reg29 = 32'h7FFF_EFFC and reg8 = reg9 = 0 on the next reads.
